utopia1_phy_cell_rx: RTL and testbench
======================================

Name: utopia1_phy_cell_rx

Overview:
- PHY-side UTOPIA-1 cell sink, directly downstream of the ATM transmitter's UTOPIA bus.
- Drives clav and samples data/soc whenever en is low.
- Assembles 53-byte NNI cells (5 header bytes, then 48 payload bytes) into a small cell buffer.
- Presents whole cells on a parallel valid/ready interface to the line framer.

Parameters:
- CELL_DEPTH, 2: number of whole-cell buffer slots (>=1).
- CNT_W, 16: width of the saturating error counters.

Ports:
- clk_in  input  1  bus clock, the transmitter's clk_out; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  8  UTOPIA byte.
- soc  input  1  start of cell; qualifies the first byte.
- en  input  1  active-low transmit enable; byte valid when 0.
- clav  output  1  cell available (space for a whole cell).
- cell_out  output  424  buffered cell; byte k at bits [423-8k -: 8].
- cell_valid  output  1  cell_out holds a complete cell.
- cell_ready  input  1  downstream accepts cell_out.
- runt_cnt  output  CNT_W  cells aborted by an early soc.
- stray_cnt  output  CNT_W  bytes with en=0 received outside a cell.
- ovf_cnt  output  CNT_W  cells dropped because no slot was free.
- hec_err_cnt  output  CNT_W  cells dropped on HEC mismatch (feature only).

Behaviour:
- Reset: clav=0, cell_valid=0, all counters 0, buffer emptied, any partial cell discarded.
  - clav may rise in the first cycle after reset deasserts.
- Only clk_in and reset exist (one clock; synchronous active-high reset).
- State machine (IDLE, CELL, DROP); byte index bidx 0..52; occ = number of complete cells buffered.
- Beat = rising edge with en==0.
- IDLE:
  - Beat with soc=1 and occ<CELL_DEPTH: store byte 0, bidx=1, go to CELL.
  - Beat with soc=1 and occ==CELL_DEPTH: ovf_cnt++, go to DROP, bidx=1.
  - Beat with soc=0: stray_cnt++, byte discarded.
- CELL:
  - Each beat stores byte at bidx, bidx++.
  - Beat at bidx==52: cell committed to the write slot (occ++, write pointer wraps modulo CELL_DEPTH), return to IDLE.
- DROP: beats consumed without storing; at bidx==52 return to IDLE.
- soc=1 on a beat while in CELL or DROP (bidx!=0):
  - runt_cnt++, partial cell discarded.
  - That byte becomes byte 0 of a new cell under the IDLE rules.
- en high: no state change (transmitter stall); gaps of any length allowed mid-cell.
- clav = (state==CELL) | (state==IDLE & occ<CELL_DEPTH).
  - A function of registers only; no combinational path from inputs.
  - Held high for a whole cell once started, so the transmitter never stalls mid-cell.
- Output:
  - cell_valid = occ>0; cell_out = slot at read pointer.
  - Pop on cell_valid&cell_ready (occ--, read pointer wraps).
  - cell_valid rises in the cycle after the edge that captured byte 52.
  - cell_out is stable while cell_valid & !cell_ready.
- Commit and pop on the same edge: occ unchanged, both pointers advance.
  - When full, a pop on the same edge as a soc beat does not admit that cell; it counts as an overflow.
- Counters saturate at all-ones.
- Reset mid-cell: partial discarded, buffered cells lost.

Optional Feature:
- Macro: UTOPIA_HEC_CHECK_EN.
- Defined:
  - Byte-serial CRC-8 (x^8+x^2+x+1, init 0) over bytes 0-3; result XOR 8'h55 compared with byte 4 at the byte-4 beat.
  - On mismatch: hec_err_cnt++, go to DROP for the rest of the cell; no commit.
- Undefined: no check, every complete cell commits, hec_err_cnt tied to 0.

Decomposition:
- Shared ATM package holds:
  - CELL_BYTES=53, HDR_BYTES=5, HEC_COSET=8'h55.
  - Function crc8_step(crc, byte).
  - Cell-byte typedef byte_t.
- One sub-module, atm_hec_crc8:
  - Byte-serial CRC accumulator with clear/enable.
  - Instantiated only under UTOPIA_HEC_CHECK_EN.
- Cell buffer stays inline: array of CELL_DEPTH x 424 bits.

Test Plan:
- Single cell, bytes 0x00..0x34 contiguous with soc on byte 0, cell_ready=1 -> cell_out bytes 0x00..0x34 in order; cell_valid high exactly one cycle, starting the cycle after the byte-52 edge; counters 0.
- Three cells back-to-back with cell_ready=0, CELL_DEPTH=2 -> clav drops after the second commit; third cell -> ovf_cnt=1. Release cell_ready -> cells 1 and 2 pop in order, clav returns high.
- en toggled high for 3 cycles at bidx 10 and 40 -> cell still assembled correctly, clav stays high throughout.
- soc reasserted at bidx 20, followed by a full 53-byte cell -> runt_cnt=1, only the second cell delivered; 2 bytes with en=0/soc=0 while IDLE -> stray_cnt=2.
- With UTOPIA_HEC_CHECK_EN, header 00 00 00 00, byte 4 = 0x55 -> accepted. Byte 4 = 0x54 -> hec_err_cnt=1, no cell_valid.
- Reset asserted at bidx 30 with one cell buffered -> cell_valid=0 and clav=0 during reset; next clean cell delivered intact.

Source files
------------

// File: rtl/utopia1_phy_cell_rx_pkg.sv
// Shared ATM cell definitions: cell geometry, HEC coset, byte type and the
// byte-serial CRC-8 (x^8+x^2+x+1) step used for header checking.
package utopia1_phy_cell_rx_pkg;

   localparam int CELL_BYTES = 53;
   localparam int HDR_BYTES  = 5;
   localparam int CELL_BITS  = 8 * CELL_BYTES;

   typedef logic [7:0] byte_t;

   localparam byte_t HEC_COSET = 8'h55;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CELL,
      ST_DROP
   } state_t;

   function automatic byte_t crc8_step(input byte_t crc, input byte_t b);
      byte_t c;
      c = crc ^ b;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/utopia1_phy_cell_rx_hec_crc8.sv
// Byte-serial CRC-8 accumulator over the ATM header; a clear on the same beat
// as an enable restarts the sum from that byte.
module atm_hec_crc8
   import utopia1_phy_cell_rx_pkg::*;
(
   input  logic  clk_in,
   input  logic  reset,
   input  logic  i_clr,
   input  logic  i_en,
   input  byte_t i_byte,
   output byte_t o_crc
);

   byte_t r_crc;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_crc <= '0;
      end else if (i_en) begin
         r_crc <= crc8_step(i_clr ? 8'h00 : r_crc, i_byte);
      end else if (i_clr) begin
         r_crc <= '0;
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/utopia1_phy_cell_rx.sv
// PHY-side UTOPIA-1 cell sink: assembles 53-byte cells into a CELL_DEPTH-slot
// buffer and hands whole cells downstream. Optional HEC check: UTOPIA_HEC_CHECK_EN.
module utopia1_phy_cell_rx
   import utopia1_phy_cell_rx_pkg::*;
#(
   parameter int CELL_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic [7:0]           data,
   input  logic                 soc,
   input  logic                 en,
   output logic                 clav,
   output logic [CELL_BITS-1:0] cell_out,
   output logic                 cell_valid,
   input  logic                 cell_ready,
   output logic [CNT_W-1:0]     runt_cnt,
   output logic [CNT_W-1:0]     stray_cnt,
   output logic [CNT_W-1:0]     ovf_cnt,
   output logic [CNT_W-1:0]     hec_err_cnt
);

   localparam int PTR_W = (CELL_DEPTH > 1) ? $clog2(CELL_DEPTH) : 1;
   localparam int OCC_W = $clog2(CELL_DEPTH + 1);
   localparam logic [5:0] LAST_IDX = 6'(CELL_BYTES - 1);

   state_t               r_state;
   logic [5:0]           r_bidx;
   logic [OCC_W-1:0]     r_occ;
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic                 r_live;
   logic [CNT_W-1:0]     r_runt_cnt;
   logic [CNT_W-1:0]     r_stray_cnt;
   logic [CNT_W-1:0]     r_ovf_cnt;
   logic [CELL_BITS-1:0] r_buf [CELL_DEPTH];

   logic       w_beat;
   logic       w_pop;
   logic       w_has_slot;
   logic       w_commit;
   logic       w_hec_bad;
   logic       w_store;
   logic [5:0] w_byte_idx;
   logic [8:0] w_bit_lo;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(CELL_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_beat     = ~en;
   assign w_pop      = cell_valid & cell_ready;
   assign w_has_slot = r_occ < OCC_W'(CELL_DEPTH);
   assign w_commit   = w_beat & ~soc & (r_state == ST_CELL) & (r_bidx == LAST_IDX) & ~w_hec_bad;
   assign w_store    = w_beat & (soc ? w_has_slot : (r_state == ST_CELL));
   assign w_byte_idx = soc ? 6'd0 : r_bidx;
   assign w_bit_lo   = 9'(CELL_BITS - 8) - {w_byte_idx, 3'b000};

`ifdef UTOPIA_HEC_CHECK_EN
   byte_t            w_crc;
   logic [CNT_W-1:0] r_hec_cnt;

   atm_hec_crc8 u_hec_crc8 (
      .clk_in (clk_in),
      .reset  (reset),
      .i_clr  (w_beat & soc),
      .i_en   (w_beat & (soc | ((r_state == ST_CELL) & (r_bidx < 6'(HDR_BYTES - 1))))),
      .i_byte (data),
      .o_crc  (w_crc)
   );

   // CRC register holds bytes 0-3 when byte 4 (the HEC) arrives.
   assign w_hec_bad = (r_state == ST_CELL) & (r_bidx == 6'(HDR_BYTES - 1)) &
                      ((w_crc ^ HEC_COSET) != data);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_hec_cnt <= '0;
      end else if (w_beat & ~soc & w_hec_bad & ~&r_hec_cnt) begin
         r_hec_cnt <= r_hec_cnt + 1'b1;
      end
   end

   assign hec_err_cnt = r_hec_cnt;
`else
   assign w_hec_bad   = 1'b0;
   assign hec_err_cnt = '0;
`endif

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_bidx      <= '0;
         r_occ       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_live      <= 1'b0;
         r_runt_cnt  <= '0;
         r_stray_cnt <= '0;
         r_ovf_cnt   <= '0;
      end else begin
         r_live <= 1'b1;
         r_occ  <= r_occ + OCC_W'(w_commit) - OCC_W'(w_pop);
         if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_beat) begin
            if (soc) begin
               // An soc mid-cell aborts the partial and restarts on this byte.
               if ((r_state != ST_IDLE) && ~&r_runt_cnt) r_runt_cnt <= r_runt_cnt + 1'b1;
               r_bidx <= 6'd1;
               if (w_has_slot) begin
                  r_state <= ST_CELL;
               end else begin
                  r_state <= ST_DROP;
                  if (~&r_ovf_cnt) r_ovf_cnt <= r_ovf_cnt + 1'b1;
               end
            end else begin
               case (r_state)
                  ST_IDLE: if (~&r_stray_cnt) r_stray_cnt <= r_stray_cnt + 1'b1;
                  ST_CELL: begin
                     if (w_hec_bad) begin
                        r_state <= ST_DROP;
                        r_bidx  <= r_bidx + 1'b1;
                     end else if (r_bidx == LAST_IDX) begin
                        r_state  <= ST_IDLE;
                        r_bidx   <= '0;
                        r_wr_ptr <= ptr_inc(r_wr_ptr);
                     end else begin
                        r_bidx <= r_bidx + 1'b1;
                     end
                  end
                  ST_DROP: begin
                     if (r_bidx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_bidx  <= '0;
                     end else begin
                        r_bidx <= r_bidx + 1'b1;
                     end
                  end
                  default: r_state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   // NOTE: the cell buffer is deliberately not reset; occupancy alone decides validity.
   always_ff @(posedge clk_in) begin
      if (w_store & ~reset) r_buf[r_wr_ptr][w_bit_lo +: 8] <= data;
   end

   assign cell_valid = (r_occ != '0);
   assign cell_out   = r_buf[r_rd_ptr];
   assign clav       = r_live & ((r_state == ST_CELL) | ((r_state == ST_IDLE) & w_has_slot));
   assign runt_cnt   = r_runt_cnt;
   assign stray_cnt  = r_stray_cnt;
   assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_utopia1_phy_cell_rx.sv
// Scoreboard bench for utopia1_phy_cell_rx: cells expected for delivery are
// queued when driven and compared when popped on the valid/ready interface.
module tb_utopia1_phy_cell_rx;

   import utopia1_phy_cell_rx_pkg::*;

`ifdef UTOPIA_HEC_CHECK_EN
   localparam bit HEC_ON = 1'b1;
`else
   localparam bit HEC_ON = 1'b0;
`endif

   logic         clk_in;
   logic         reset;
   logic [7:0]   data;
   logic         soc;
   logic         en;
   logic         clav;
   logic [423:0] cell_out;
   logic         cell_valid;
   logic         cell_ready;
   logic [15:0]  runt_cnt;
   logic [15:0]  stray_cnt;
   logic [15:0]  ovf_cnt;
   logic [15:0]  hec_err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [423:0] sb_q[$];
   logic [423:0] prev_out;
   bit           prev_hold = 1'b0;

   utopia1_phy_cell_rx #(.CELL_DEPTH(2), .CNT_W(16)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .data        (data),
      .soc         (soc),
      .en          (en),
      .clav        (clav),
      .cell_out    (cell_out),
      .cell_valid  (cell_valid),
      .cell_ready  (cell_ready),
      .runt_cnt    (runt_cnt),
      .stray_cnt   (stray_cnt),
      .ovf_cnt     (ovf_cnt),
      .hec_err_cnt (hec_err_cnt)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [423:0] obs, input logic [423:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bitwise-serial reference for the header CRC.
   function automatic logic [7:0] ref_crc8(input logic [423:0] c);
      logic [7:0] crc = 8'h00;
      logic [7:0] b;
      logic       fb;
      for (int k = 0; k < 4; k++) begin
         b = c[423-8*k -: 8];
         for (int i = 7; i >= 0; i--) begin
            fb  = crc[7] ^ b[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return crc;
   endfunction

   function automatic logic [423:0] make_cell(input logic [7:0] base);
      logic [423:0] c;
      for (int k = 0; k < 53; k++) c[423-8*k -: 8] = base + 8'(k);
      c[423-8*4 -: 8] = ref_crc8(c) ^ 8'h55;
      return c;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_in); #1;
         en  = 1'b1;
         soc = 1'b0;
      end
   endtask

   task automatic drive_beat(input logic [7:0] b, input logic s);
      @(posedge clk_in); #1;
      data = b;
      soc  = s;
      en   = 1'b0;
   endtask

   task automatic send_cell(input logic [423:0] c, input int n, input int gap_a,
                            input int gap_b, input bit push);
      for (int k = 0; k < n; k++) begin
         if (k == gap_a || k == gap_b) begin
            repeat (3) begin
               @(posedge clk_in); #1;
               en  = 1'b1;
               soc = 1'b0;
               @(negedge clk_in);
               check("clav_gap", clav, 1'b1);
            end
         end
         drive_beat(c[423-8*k -: 8], k == 0);
      end
      idle(1);
      if (push) sb_q.push_back(c);
   endtask

   task automatic wait_drain(input int max_cycles);
      int cyc = 0;
      while (sb_q.size() != 0 && cyc < max_cycles) begin
         @(posedge clk_in);
         cyc++;
      end
      check("drain_empty", sb_q.size(), 0);
   endtask

   // Output monitor: pops the scoreboard on each handshake, checks hold stability.
   always @(negedge clk_in) begin
      if (!reset && cell_valid && cell_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_cell", cell_valid, 1'b0);
         end else begin
            check("cell_out", cell_out, sb_q.pop_front());
         end
         prev_hold = 1'b0;
      end else if (!reset && cell_valid) begin
         if (prev_hold) check("cell_hold", cell_out, prev_out);
         prev_out  = cell_out;
         prev_hold = 1'b1;
      end else begin
         prev_hold = 1'b0;
      end
   end

   initial begin
      logic [423:0] c;
      reset      = 1'b1;
      data       = 8'h00;
      soc        = 1'b0;
      en         = 1'b1;
      cell_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_clav", clav, 1'b0);
      check("rst_valid", cell_valid, 1'b0);
      check("rst_runt", runt_cnt, 0);
      check("rst_ovf", ovf_cnt, 0);
      reset = 1'b0;
      idle(2);
      check("clav_after_rst", clav, 1'b1);

      // Single contiguous cell 0x00..0x34, one-cycle valid pulse
      cell_ready = 1'b1;
      c = make_cell(8'h00);
      send_cell(c, 53, -1, -1, 1'b1);
      check("valid_rise", cell_valid, 1'b1);
      @(posedge clk_in); #1;
      check("valid_one_cycle", cell_valid, 1'b0);
      check("t1_runt", runt_cnt, 0);
      check("t1_stray", stray_cnt, 0);
      check("t1_ovf", ovf_cnt, 0);
      check("t1_hec", hec_err_cnt, 0);
      wait_drain(10);

      // Three back-to-back cells into a two-slot buffer with ready low
      cell_ready = 1'b0;
      send_cell(make_cell(8'h40), 53, -1, -1, 1'b1);
      check("clav_one_full", clav, 1'b1);
      send_cell(make_cell(8'h80), 53, -1, -1, 1'b1);
      check("clav_two_full", clav, 1'b0);
      check("valid_full", cell_valid, 1'b1);
      send_cell(make_cell(8'hC0), 53, -1, -1, 1'b0);
      check("ovf_one", ovf_cnt, 1);
      cell_ready = 1'b1;
      wait_drain(20);
      idle(2);
      check("clav_recovered", clav, 1'b1);
      check("valid_drained", cell_valid, 1'b0);

      // Transmitter stalls mid-cell
      send_cell(make_cell(8'h10), 53, 10, 40, 1'b1);
      wait_drain(10);

      // Runt then a full cell; then stray bytes
      send_cell(make_cell(8'h20), 20, -1, -1, 1'b0);
      send_cell(make_cell(8'h60), 53, -1, -1, 1'b1);
      wait_drain(10);
      check("runt_one", runt_cnt, 1);
      drive_beat(8'hAA, 1'b0);
      drive_beat(8'hBB, 1'b0);
      idle(1);
      check("stray_two", stray_cnt, 2);
      check("ovf_still_one", ovf_cnt, 1);

      // HEC: zero header with coset HEC, then a corrupted HEC
      c = make_cell(8'h30);
      c[423:384] = 40'h00_0000_0055;
      send_cell(c, 53, -1, -1, 1'b1);
      wait_drain(10);
      c[391:384] = 8'h54;
      send_cell(c, 53, -1, -1, !HEC_ON);
      check("hec_valid", cell_valid, !HEC_ON);
      check("hec_cnt", hec_err_cnt, HEC_ON ? 1 : 0);
      wait_drain(10);

      // Reset with one cell buffered and another partially received
      cell_ready = 1'b0;
      send_cell(make_cell(8'h50), 53, -1, -1, 1'b0);
      check("pre_rst_valid", cell_valid, 1'b1);
      send_cell(make_cell(8'h90), 30, -1, -1, 1'b0);
      reset = 1'b1;
      @(posedge clk_in); #1;
      check("mid_rst_valid", cell_valid, 1'b0);
      check("mid_rst_clav", clav, 1'b0);
      check("mid_rst_runt", runt_cnt, 0);
      check("mid_rst_stray", stray_cnt, 0);
      @(posedge clk_in); #1;
      reset      = 1'b0;
      cell_ready = 1'b1;
      idle(2);
      check("post_rst_clav", clav, 1'b1);
      send_cell(make_cell(8'hA0), 53, -1, -1, 1'b1);
      wait_drain(10);
      idle(3);
      check("final_valid", cell_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
